mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, word address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter D_MAX_RUN, default 3, maximum consecutive contested grants to the data port before the instruction port is forced.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_req  in  1  instruction-fetch read request; held with i_addr stable until i_ack.
REQ-007 i_addr  in  ADDR_W  instruction fetch address.
REQ-008 i_ack  out  1  instruction request issued to memory this cycle.
REQ-009 i_rvalid  out  1  i_rdata valid; exactly one cycle after i_ack.
REQ-010 i_rdata  out  DATA_W  instruction read data.
REQ-011 d_req  in  1  data-port request; held with d_we, d_addr and d_wdata stable until d_ack.
REQ-012 d_we  in  1  1 = write, 0 = read.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  write data.
REQ-015 d_ack  out  1  data request issued to memory this cycle.
REQ-016 d_rvalid  out  1  d_rdata valid; exactly one cycle after a read d_ack; never after a write.
REQ-017 d_rdata  out  DATA_W  data read data.
REQ-018 mem_w_en  out  1  to memory write enable.
REQ-019 mem_addr  out  ADDR_W  to memory address.
REQ-020 mem_d_in  out  DATA_W  to memory write data.
REQ-021 mem_d_out  in  DATA_W  from memory registered read data; the memory holds its previous value during a write cycle.

Function
REQ-022 The block SHALL issue at most one memory access per cycle; grant, i_ack/d_ack and mem_* SHALL be combinational from requests and registered arbitration state.
REQ-023 Arbitration state SHALL be a two-state FSM, LAST_I and LAST_D, recording the port granted most recently; on an idle cycle the state SHALL hold.
REQ-024 With only one request asserted, that port SHALL be granted in the same cycle.
REQ-025 With both requests asserted, the data port SHALL be granted unless run_cnt equals D_MAX_RUN, in which case the instruction port SHALL be granted.
REQ-026 run_cnt SHALL increment on each contested data grant, saturate at D_MAX_RUN, and clear on any instruction grant.
REQ-027 With no grant, mem_w_en SHALL be 0, and mem_addr and mem_d_in SHALL hold their last driven values.
REQ-028 On an instruction grant: mem_addr = i_addr, mem_w_en = 0.
REQ-029 On a data grant: mem_addr = d_addr, mem_d_in = d_wdata, mem_w_en = d_we.
REQ-030 A one-bit rd_owner register and a one-bit rd_pend register SHALL capture, for each granted read, which port receives mem_d_out next cycle.
REQ-031 i_rdata and d_rdata SHALL both be driven from mem_d_out unconditionally; only the rvalid signals are steered.
REQ-032 A data write immediately followed by a read of the same address SHALL return the newly written value one cycle after the read's d_ack.
REQ-033 Back-to-back grants SHALL sustain one access per cycle with no bubble.
REQ-034 Deasserting a request without an ack is illegal; behaviour is unspecified.

Reset
REQ-035 While rst = 1: i_ack = d_ack = i_rvalid = d_rvalid = mem_w_en = 0, FSM = LAST_D, run_cnt = 0, rd_pend = 0.
REQ-036 A read acknowledged in the cycle rst is asserted SHALL NOT produce an rvalid.
REQ-037 In the first cycle after reset deasserts, a contested cycle SHALL grant the data port.

Structure
REQ-038 ADDR_W, DATA_W and the FSM state encodings SHALL live in the shared header mem_arb_defs.
REQ-039 Grant selection (REQ-024 to REQ-026) SHALL be a sub-module mem_arb_pick; everything else SHALL stay in mem_arbiter.

Verification
REQ-040 i_req only, i_addr=0x0010, mem holds 0x12345678 at 0x0010 -> i_ack in cycle 0; i_rvalid=1 and i_rdata=0x12345678 in cycle 1.
REQ-041 d_req write 0x0020 <- 0xDEADBEEF, then read 0x0020 next cycle -> mem_w_en=1 in cycle 0; d_rvalid=1 and d_rdata=0xDEADBEEF in cycle 2; no d_rvalid in cycle 1.
REQ-042 i_req and d_req (reads) held continuously, D_MAX_RUN=3 -> grant pattern D,D,D,I,D,D,D,I...; one ack per cycle.
REQ-043 Contested cycle in which the data port issues a write -> i_ack=0, mem_w_en=1; i_ack is given the following cycle with the correct i_rvalid after.
REQ-044 rst asserted in the same cycle as a data read ack -> d_rvalid=0 next cycle; all outputs at reset values; contested cycle after release grants D.
REQ-045 Neither port requests for 5 cycles -> mem_w_en=0 throughout; FSM and run_cnt unchanged.

Source files
------------

// File: rtl/mem_arb_defs_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// arbitration state encoding and a counter-width helper.
package mem_arb_defs;

    localparam int MEM_ADDR_W    = 13;
    localparam int MEM_DATA_W    = 32;
    localparam int MEM_D_MAX_RUN = 3;

    // Which port received the most recent grant.
    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } arb_state_e;

    // Bits needed to count contested data grants up to max_run inclusive.
    function automatic int run_cnt_w(input int max_run);
        return (max_run < 1) ? 1 : $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: a lone request wins immediately; on contention the data
// port wins until it has taken D_MAX_RUN contested grants in a row.
module mem_arb_pick
    import mem_arb_defs::*;
#(
    parameter int D_MAX_RUN = MEM_D_MAX_RUN,
    parameter int CNT_W     = run_cnt_w(MEM_D_MAX_RUN)
) (
    input  logic             i_ireq,
    input  logic             i_dreq,
    input  logic [CNT_W-1:0] i_run_cnt,
    output logic             o_gnt_i,
    output logic             o_gnt_d
);

    logic w_force_i;

    assign w_force_i = (i_run_cnt == CNT_W'(D_MAX_RUN));

    // Pick at most one winner from the current requests and run count.
    always_comb begin
        o_gnt_i = 1'b0;
        o_gnt_d = 1'b0;
        if (i_ireq && i_dreq) begin
            o_gnt_i = w_force_i;
            o_gnt_d = ~w_force_i;
        end else begin
            o_gnt_i = i_ireq;
            o_gnt_d = i_dreq;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port
// synchronous memory. Grants and memory controls are combinational from the
// requests and registered state; read data returns one cycle after the ack.
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int D_MAX_RUN = MEM_D_MAX_RUN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_in,
    input  logic [DATA_W-1:0] mem_d_out
);

    localparam int CNT_W = run_cnt_w(D_MAX_RUN);

    arb_state_e        r_state;
    logic [CNT_W-1:0]  r_run_cnt;
    logic              r_rd_pend;
    logic              r_rd_owner;   // 1 = data port owns the returning word
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_d_in;

    logic w_pick_i;
    logic w_pick_d;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_contested;

    mem_arb_pick #(
        .D_MAX_RUN (D_MAX_RUN),
        .CNT_W     (CNT_W)
    ) u_pick (
        .i_ireq    (i_req),
        .i_dreq    (d_req),
        .i_run_cnt (r_run_cnt),
        .o_gnt_i   (w_pick_i),
        .o_gnt_d   (w_pick_d)
    );

    // Reset suppresses every grant so nothing is issued while rst is high.
    assign w_gnt_i     = w_pick_i & ~rst;
    assign w_gnt_d     = w_pick_d & ~rst;
    assign w_contested = i_req & d_req;

    assign i_ack    = w_gnt_i;
    assign d_ack    = w_gnt_d;
    assign mem_w_en = w_gnt_d & d_we;

    // Read data is shared; only the valid strobes are steered to a port.
    assign i_rdata  = mem_d_out;
    assign d_rdata  = mem_d_out;
    assign i_rvalid = r_rd_pend & ~r_rd_owner & ~rst;
    assign d_rvalid = r_rd_pend &  r_rd_owner & ~rst;

    // Memory address/data follow the winner; they hold when nobody is granted.
    always_comb begin
        mem_addr = r_mem_addr;
        mem_d_in = r_mem_d_in;
        if (w_gnt_i) begin
            mem_addr = i_addr;
        end else if (w_gnt_d) begin
            mem_addr = d_addr;
            mem_d_in = d_wdata;
        end else begin
            mem_addr = r_mem_addr;
            mem_d_in = r_mem_d_in;
        end
    end

    // Arbitration FSM: remember the most recently granted port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LAST_D;
        end else if (w_gnt_i) begin
            r_state <= LAST_I;
        end else if (w_gnt_d) begin
            r_state <= LAST_D;
        end else begin
            r_state <= r_state;
        end
    end

    // Contested data-grant run length, saturating, cleared by an instruction grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= {CNT_W{1'b0}};
        end else if (w_gnt_i) begin
            r_run_cnt <= {CNT_W{1'b0}};
        end else if (w_gnt_d && w_contested && (r_run_cnt != CNT_W'(D_MAX_RUN))) begin
            r_run_cnt <= r_run_cnt + CNT_W'(1);
        end else begin
            r_run_cnt <= r_run_cnt;
        end
    end

    // Track which port receives next cycle's memory read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend  <= w_gnt_i | (w_gnt_d & ~d_we);
            r_rd_owner <= w_gnt_d;
        end
    end

    // Remember the last driven memory address and write data for idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr <= {ADDR_W{1'b0}};
            r_mem_d_in <= {DATA_W{1'b0}};
        end else begin
            r_mem_addr <= mem_addr;
            r_mem_d_in <= mem_d_in;
        end
    end

endmodule
